// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the ysyx_24100005 instruction fetch path.
//   ifu_state_t      : fetch FSM states with a 3-bit encoding
//   RESP_OKAY        : AXI4-Lite read response for a good transfer
//   RESET_PC_DEFAULT : address held in the fetch address register after reset
//   pc_aligned()     : true when the low PC bits select a 32-bit word
package ysyx_24100005_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE  = 3'd0,
        IFU_ADDR  = 3'd1,
        IFU_DATA  = 3'd2,
        IFU_HOLD  = 3'd3,
        IFU_DRAIN = 3'd4
    } ifu_state_t;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    function automatic logic pc_aligned(input logic [1:0] pc_low);
        return (pc_low == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_24100005_ifu_if.sv
// Instruction-memory read channel (AXI4-Lite-style AR + R) between the
// fetch unit and instruction memory.
//   master : fetch unit side (drives mem_arvalid/mem_araddr/mem_rready)
//   slave  : memory side (drives mem_arready/mem_rvalid/mem_rdata/mem_rresp)
interface ysyx_24100005_ifu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_arvalid;
    logic              mem_arready;
    logic [ADDR_W-1:0] mem_araddr;
    logic              mem_rvalid;
    logic              mem_rready;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        mem_rresp;

    modport master (
        output mem_arvalid,
        output mem_araddr,
        output mem_rready,
        input  mem_arready,
        input  mem_rvalid,
        input  mem_rdata,
        input  mem_rresp
    );

    modport slave (
        input  mem_arvalid,
        input  mem_araddr,
        input  mem_rready,
        output mem_arready,
        output mem_rvalid,
        output mem_rdata,
        output mem_rresp
    );
endinterface

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit for the ysyx_24100005 core.
// Takes the PC, issues one read on the instruction-memory channel and hands
// the fetched word to the core over a valid/ready handshake. Misaligned PCs
// are answered locally with fetch_err, bus errors are flagged via fetch_err,
// and flush cancels any in-flight or held fetch.
//   clk, rst              : clock, asynchronous active-high reset
//   pc, pc_valid          : fetch request (sampled only while idle)
//   flush                 : pipeline redirect
//   inst, inst_valid,
//   inst_ready, fetch_err : fetched word handshake towards the core
//   mem                   : read channel to instruction memory (master side)
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    pc,
    input  logic                 pc_valid,
    input  logic                 flush,
    output logic [DATA_W-1:0]    inst,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic                 fetch_err,
    ysyx_24100005_ifu_if.master  mem
);

    localparam logic [2:0] S_IDLE  = IFU_IDLE;
    localparam logic [2:0] S_ADDR  = IFU_ADDR;
    localparam logic [2:0] S_DATA  = IFU_DATA;
    localparam logic [2:0] S_HOLD  = IFU_HOLD;
    localparam logic [2:0] S_DRAIN = IFU_DRAIN;

    logic [2:0]        state_reg,  state_next;
    logic              cancel_reg, cancel_next;   // flush seen while the AR beat was pending
    logic [ADDR_W-1:0] araddr_reg, araddr_next;
    logic [DATA_W-1:0] inst_reg,   inst_next;
    logic              err_reg,    err_next;

    always_comb begin
        state_next  = state_reg;
        cancel_next = cancel_reg;
        araddr_next = araddr_reg;
        inst_next   = inst_reg;
        err_next    = err_reg;

        case (state_reg)
            S_IDLE: begin
                // flush is meaningless here; a coincident pc_valid still starts a fetch
                if (pc_valid) begin
                    if (pc_aligned(pc[1:0])) begin
                        araddr_next = pc;
                        state_next  = S_ADDR;
                    end else begin
                        // answered locally, nothing goes out on the bus
                        inst_next  = '0;
                        err_next   = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end

            S_ADDR: begin
                // arvalid cannot be withdrawn, so a flush here only marks the
                // request; its read data is thrown away in DRAIN
                if (flush) begin
                    cancel_next = 1'b1;
                end
                if (mem.mem_arready) begin
                    state_next = (cancel_reg || flush) ? S_DRAIN : S_DATA;
                end
            end

            S_DATA: begin
                if (flush) begin
                    if (mem.mem_rvalid) begin
                        state_next = S_IDLE;
                    end else begin
                        cancel_next = 1'b1;
                        state_next  = S_DRAIN;
                    end
                end else if (mem.mem_rvalid) begin
                    inst_next  = mem.mem_rdata;
                    err_next   = (mem.mem_rresp != RESP_OKAY);
                    state_next = S_HOLD;
                end
            end

            S_HOLD: begin
                // flush outranks inst_ready; both return to IDLE, but only the
                // handshake counts as a delivered instruction
                if (flush || inst_ready) begin
                    state_next = S_IDLE;
                end
            end

            S_DRAIN: begin
                if (mem.mem_rvalid) begin
                    cancel_next = 1'b0;
                    state_next  = S_IDLE;
                end
            end

            default: begin
                state_next  = S_IDLE;
                cancel_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cancel_reg <= 1'b0;
            araddr_reg <= RESET_PC;
            inst_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cancel_reg <= cancel_next;
            araddr_reg <= araddr_next;
            inst_reg   <= inst_next;
            err_reg    <= err_next;
        end
    end

    // handshake outputs are pure state decodes so reset clears them at once
    assign mem.mem_arvalid = (state_reg == S_ADDR);
    assign mem.mem_rready  = (state_reg == S_DATA) || (state_reg == S_DRAIN);
    assign mem.mem_araddr  = araddr_reg;
    assign inst_valid      = (state_reg == S_HOLD);
    assign inst            = inst_reg;
    assign fetch_err       = err_reg;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Self-checking bench for ysyx_24100005_ifu: a vector table of single
// fetches with configurable wait states, plus hand-written flush and
// asynchronous-reset sequences. Expected instructions and AR addresses are
// queued when stimulus is driven and popped when the DUT hands them over.
module tb_ysyx_24100005_ifu;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_err;

    ysyx_24100005_ifu_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    ysyx_24100005_ifu #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err),
        .mem        (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_dly;
        int          r_dly;
        int          rdy_dly;
        logic        fl_req;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ar_q[$];
    int          n_checks;
    int          n_fail;
    vec_t        vecs[9];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // scoreboard: runs at every falling edge
    task automatic monitor();
        exp_t e;
        logic [31:0] a;
        if (mem_bus.mem_arvalid && mem_bus.mem_arready) begin
            if (ar_q.size() == 0) begin
                chk("ar_unexpected", 32'(mem_bus.mem_arvalid), 32'd0);
            end else begin
                a = ar_q.pop_front();
                chk("ar_addr", mem_bus.mem_araddr, a);
            end
        end
        if (exp_q.size() == 0) begin
            chk("inst_valid_spurious", 32'(inst_valid), 32'd0);
        end else if (inst_valid && inst_ready && !flush) begin
            e = exp_q.pop_front();
            chk("inst", inst, e.inst);
            chk("fetch_err", 32'(fetch_err), 32'(e.err));
        end
    endtask

    task automatic neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        neg();
        chk({name, "_arvalid"}, 32'(mem_bus.mem_arvalid), 32'd0);
        chk({name, "_rready"}, 32'(mem_bus.mem_rready), 32'd0);
        chk({name, "_inst_valid"}, 32'(inst_valid), 32'd0);
        pos();
    endtask

    // request accepted and AR beat taken with no waits; returns in DATA
    task automatic fetch_to_data(input logic [31:0] a);
        pc = a;
        pc_valid = 1'b1;
        ar_q.push_back(a);
        neg();
        pos();
        pc_valid = 1'b0;
        pc = $urandom;
        mem_bus.mem_arready = 1'b1;
        neg();
        chk("arvalid_zero_wait", 32'(mem_bus.mem_arvalid), 32'd1);
        pos();
        mem_bus.mem_arready = 1'b0;
    endtask

    task automatic run_fetch(input vec_t v);
        logic aligned;
        aligned = (v.pc[1:0] == 2'b00);
        pc = v.pc;
        pc_valid = 1'b1;
        flush = v.fl_req;
        exp_q.push_back('{inst: v.exp_inst, err: v.exp_err});
        if (aligned) ar_q.push_back(v.pc);
        neg();
        chk("req_cycle_arvalid", 32'(mem_bus.mem_arvalid), 32'd0);
        pos();
        pc_valid = 1'b0;
        flush = 1'b0;
        pc = $urandom;   // must be ignored outside IDLE
        if (aligned) begin
            for (int i = 0; i < v.ar_dly; i++) begin
                neg();
                chk("arvalid_held", 32'(mem_bus.mem_arvalid), 32'd1);
                chk("araddr_held", mem_bus.mem_araddr, v.pc);
                pos();
            end
            mem_bus.mem_arready = 1'b1;
            neg();
            chk("arvalid", 32'(mem_bus.mem_arvalid), 32'd1);
            pos();
            mem_bus.mem_arready = 1'b0;
            for (int i = 0; i < v.r_dly; i++) begin
                neg();
                chk("rready_wait", 32'(mem_bus.mem_rready), 32'd1);
                pos();
            end
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata = v.rdata;
            mem_bus.mem_rresp = v.rresp;
            neg();
            chk("rready", 32'(mem_bus.mem_rready), 32'd1);
            pos();
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata = $urandom;
            mem_bus.mem_rresp = 2'b00;
        end
        for (int i = 0; i < v.rdy_dly; i++) begin
            neg();
            chk("hold_valid", 32'(inst_valid), 32'd1);
            chk("hold_inst", inst, v.exp_inst);
            chk("hold_err", 32'(fetch_err), 32'(v.exp_err));
            chk("hold_no_arvalid", 32'(mem_bus.mem_arvalid), 32'd0);
            pos();
        end
        inst_ready = 1'b1;
        neg();
        chk("inst_valid", 32'(inst_valid), 32'd1);
        pos();
        inst_ready = 1'b0;
        chk_idle("after_fetch");
        $display("fetch pc=%h inst=%h err=%0d checks=%0d", v.pc, v.exp_inst, v.exp_err, n_checks);
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        pc = 32'h0;
        pc_valid = 1'b0;
        flush = 1'b0;
        inst_ready = 1'b0;
        mem_bus.mem_arready = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        mem_bus.mem_rresp = 2'b00;

        //                 pc            rdata         rresp  ar r  rdy fl  exp_inst      err
        vecs[0] = '{32'h8000_0000, 32'h0010_0093, 2'b00, 0, 0, 0, 1'b0, 32'h0010_0093, 1'b0};
        vecs[1] = '{32'h8000_0004, 32'h1234_5678, 2'b00, 3, 5, 4, 1'b0, 32'h1234_5678, 1'b0};
        vecs[2] = '{32'h8000_0002, 32'hFFFF_FFFF, 2'b00, 0, 0, 0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h8000_0008, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{32'h8000_0003, 32'h0000_0000, 2'b00, 0, 0, 2, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h8000_000C, 32'hA5A5_0F0F, 2'b01, 1, 2, 1, 1'b0, 32'hA5A5_0F0F, 1'b1};
        vecs[6] = '{32'h8000_0001, 32'h0000_0000, 2'b00, 0, 0, 1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'h0000_1000, 32'h0020_0113, 2'b00, 2, 0, 0, 1'b1, 32'h0020_0113, 1'b0};
        vecs[8] = '{32'h8000_0014, 32'h3333_4444, 2'b11, 0, 1, 0, 1'b0, 32'h3333_4444, 1'b1};

        #1;
        chk("rst_araddr", mem_bus.mem_araddr, 32'h8000_0000);
        chk("rst_arvalid", 32'(mem_bus.mem_arvalid), 32'd0);
        chk("rst_rready", 32'(mem_bus.mem_rready), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle("post_reset");

        for (int k = 0; k < 9; k++) begin
            run_fetch(vecs[k]);
        end

        // flush in ADDR before arready: AR completes, data is drained
        pc = 32'h8000_0020;
        pc_valid = 1'b1;
        ar_q.push_back(32'h8000_0020);
        neg();
        pos();
        pc_valid = 1'b0;
        flush = 1'b1;
        neg();
        chk("addr_flush_arvalid", 32'(mem_bus.mem_arvalid), 32'd1);
        pos();
        flush = 1'b0;
        neg();
        chk("arvalid_not_withdrawn", 32'(mem_bus.mem_arvalid), 32'd1);
        pos();
        mem_bus.mem_arready = 1'b1;
        neg();
        pos();
        mem_bus.mem_arready = 1'b0;
        neg();
        chk("drain_rready", 32'(mem_bus.mem_rready), 32'd1);
        chk("drain_arvalid", 32'(mem_bus.mem_arvalid), 32'd0);
        pos();
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata = 32'h1111_1111;
        neg();
        chk("drain_rready_beat", 32'(mem_bus.mem_rready), 32'd1);
        pos();
        mem_bus.mem_rvalid = 1'b0;
        chk_idle("after_drain");
        $display("seq flush_in_addr done checks=%0d", n_checks);

        // flush coincident with rvalid in DATA: straight back to IDLE
        fetch_to_data(32'h8000_0030);
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata = 32'h2222_2222;
        flush = 1'b1;
        neg();
        pos();
        mem_bus.mem_rvalid = 1'b0;
        flush = 1'b0;
        chk_idle("flush_rvalid");
        $display("seq flush_with_rvalid done checks=%0d", n_checks);

        v = '{32'h8000_0010, 32'h0000_0513, 2'b00, 0, 0, 0, 1'b0, 32'h0000_0513, 1'b0};
        run_fetch(v);

        // flush in DATA before rvalid: DRAIN until the beat arrives
        fetch_to_data(32'h8000_0034);
        flush = 1'b1;
        neg();
        pos();
        flush = 1'b0;
        neg();
        chk("data_flush_drain_rready", 32'(mem_bus.mem_rready), 32'd1);
        pos();
        mem_bus.mem_rvalid = 1'b1;
        neg();
        pos();
        mem_bus.mem_rvalid = 1'b0;
        chk_idle("data_flush_drain");
        $display("seq flush_in_data done checks=%0d", n_checks);

        // flush in HOLD wins over inst_ready
        fetch_to_data(32'h8000_0038);
        exp_q.push_back('{inst: 32'hCAFE_F00D, err: 1'b1});
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata = 32'hCAFE_F00D;
        mem_bus.mem_rresp = 2'b10;
        neg();
        pos();
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rresp = 2'b00;
        inst_ready = 1'b1;
        flush = 1'b1;
        neg();
        chk("hold_flush_valid", 32'(inst_valid), 32'd1);
        chk("hold_flush_inst", inst, 32'hCAFE_F00D);
        pos();
        void'(exp_q.pop_front());
        inst_ready = 1'b0;
        flush = 1'b0;
        chk_idle("hold_flush");
        $display("seq flush_in_hold done checks=%0d", n_checks);

        // asynchronous reset pulsed between edges while in DATA
        fetch_to_data(32'h8000_0040);
        neg();
        chk("pre_rst_rready", 32'(mem_bus.mem_rready), 32'd1);
        chk("pre_rst_araddr", mem_bus.mem_araddr, 32'h8000_0040);
        pos();
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_araddr", mem_bus.mem_araddr, 32'h8000_0000);
        chk("async_rst_rready", 32'(mem_bus.mem_rready), 32'd0);
        chk("async_rst_arvalid", 32'(mem_bus.mem_arvalid), 32'd0);
        chk("async_rst_inst", inst, 32'd0);
        chk("async_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("async_rst_fetch_err", 32'(fetch_err), 32'd0);
        #1;
        rst = 1'b0;
        chk_idle("after_async_rst");
        $display("seq async_reset done checks=%0d", n_checks);

        v = '{32'h8000_0050, 32'h7654_3210, 2'b00, 1, 1, 1, 1'b0, 32'h7654_3210, 1'b0};
        run_fetch(v);

        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("ar_queue_empty", 32'(ar_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_ifu.md
# ysyx_24100005_ifu

Instruction fetch unit for the ysyx_24100005 core. It sits directly upstream of the core top: it takes the current PC and issues a read request on an AXI4-Lite-style read channel to instruction memory. It returns the fetched word to the core through a valid/ready handshake, replacing the combinational `inst` input path. Variable memory latency, bus errors, misaligned PCs and pipeline redirects (flush) are all handled here.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: instruction width.
- `RESET_PC`, default 32'h8000_0000: reset value of the `mem_araddr` register.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `pc`  in  ADDR_W  fetch address from the PC register.
- `pc_valid`  in  1  core requests a fetch of `pc`.
- `flush`  in  1  redirect; cancels any in-flight or held fetch.
- `inst`  out  DATA_W  fetched instruction, registered.
- `inst_valid`  out  1  `inst` is valid.
- `inst_ready`  in  1  core consumes `inst`.
- `fetch_err`  out  1  qualifies `inst`; misaligned PC or bus error.
- `mem_arvalid`  out  1; `mem_arready`  in  1; `mem_araddr`  out  ADDR_W.
- `mem_rvalid`  in  1; `mem_rready`  out  1; `mem_rdata`  in  DATA_W; `mem_rresp`  in  2.

## Operation
- FSM states: IDLE, ADDR, DATA, HOLD, DRAIN. All outputs are registered or decoded from state.
- IDLE:
  - `pc_valid`=1 with `pc[1:0]`==0: latch `pc` into `mem_araddr`, then go to ADDR.
  - `pc_valid`=1 with `pc[1:0]`!=0: no bus request is issued. Set `inst`=0 and `fetch_err`=1, then go to HOLD.
  - `flush` in IDLE has no effect. A `pc_valid` in the same cycle is still accepted.
- ADDR:
  - `mem_arvalid`=1.
  - `mem_arready`=1: go to DATA, or to DRAIN if a flush is pending or `flush`=1 this cycle.
  - `arvalid` is never withdrawn before the handshake completes. A `flush` seen in ADDR sets the `cancel` flag, which is cleared on leaving DRAIN.
- DATA:
  - `mem_rready`=1.
  - `mem_rvalid`=1 and no flush: capture `mem_rdata` into `inst`. Set `fetch_err`=(`mem_rresp`!=2'b00), then go to HOLD.
  - `flush`=1 with `mem_rvalid`=1 in the same cycle: discard the data and go to IDLE.
  - `flush`=1 without `mem_rvalid`: go to DRAIN.
- HOLD:
  - `inst_valid`=1.
  - `inst_ready`=1: go to IDLE.
  - `flush`=1: drop `inst_valid` and go to IDLE. `flush` has priority over `inst_ready`.
  - `inst` and `fetch_err` stay stable until the handshake completes.
- DRAIN:
  - `mem_rready`=1.
  - `mem_rvalid`=1: discard the data and go to IDLE.
- Only one transaction is outstanding at a time.
- `pc` is sampled only in IDLE. Changes to `pc` elsewhere are ignored.

## Timing
- Reset values: state=IDLE, `mem_arvalid`=0, `mem_rready`=0, `mem_araddr`=`RESET_PC`, `inst`=0, `inst_valid`=0, `fetch_err`=0, `cancel`=0. Reset takes effect immediately, asynchronously. A reset mid-transaction abandons it; memory must tolerate the dropped `rready`.
- Minimum latency with zero-wait memory:
  - cycle 0: `pc_valid`
  - cycle 1: `arvalid`, with `arready`
  - cycle 2: `rvalid`
  - cycle 3: `inst_valid`
  - cycle 4: IDLE if `inst_ready` was high in cycle 3.
- Throughput: at most one instruction per 4 cycles.
- Misaligned path: `pc_valid` in cycle 0 gives `inst_valid`+`fetch_err` in cycle 1.
- Memory wait states extend ADDR or DATA indefinitely. There is no timeout.

## Structure
- Shared package `ysyx_24100005_pkg` holds:
  - the `ifu_state_t` enum (5 states, 3-bit encoding);
  - `RESP_OKAY`=2'b00;
  - `RESET_PC_DEFAULT`=32'h8000_0000.
- No new sub-module. The `inst`/`mem_araddr` registers may instantiate the existing `ysyx_24100005_Reg`, but its synchronous reset must be replaced by the asynchronous `rst`. The FSM stays inline.

## Test plan
- Zero-wait fetch: `pc`=32'h8000_0000 with `mem_rdata`=32'h0010_0093 and `inst_ready` tied 1. Required: `mem_araddr`=32'h8000_0000 in cycle 1, `inst`=32'h0010_0093 with `inst_valid` in cycle 3, `fetch_err`=0.
- Wait states and backpressure: `arready` delayed 3 cycles, `rvalid` delayed 5 cycles, `inst_ready` low for 4 cycles. Required: `arvalid` held steady until accepted, `inst` stable through HOLD, exactly one transaction.
- Misaligned PC: `pc`=32'h8000_0002. Required: no `arvalid` ever, `inst_valid`=1 and `fetch_err`=1 in cycle 1, `inst`=0.
- Bus error: `mem_rresp`=2'b10 with `mem_rdata`=32'hDEAD_BEEF. Required: `inst`=32'hDEAD_BEEF, `fetch_err`=1.
- Flush in flight:
  - `flush` in ADDR before `arready`: the AR handshake completes, the following `rvalid` is drained, and `inst_valid` never rises.
  - `flush` coincident with `rvalid` in DATA: next state is IDLE, no `inst_valid`.
  - A new `pc`=32'h8000_0010 is then fetched correctly.
- Async reset mid-DATA: `rst` pulsed between clock edges. Required: all outputs return to reset values before the next edge, `mem_araddr`=32'h8000_0000.
